// File: rtl/mult_eval_pkg.sv
// Shared types and width helpers for the multiplier error-characterisation sequencer.
package mult_eval_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_e;

  function automatic int pw_of(input int w);
    return 2 * w;
  endfunction

  function automatic int nv_of(input int w);
    return 1 << (2 * w);
  endfunction

  function automatic int sum_w_of(input int w);
    return 4 * w;
  endfunction

  function automatic int cnt_w_of(input int w);
    return 2 * w + 1;
  endfunction

  // clog2(settle+1), never narrower than one bit so the counter always exists
  function automatic int settle_cnt_w(input int settle);
    int w;
    w = 1;
    while ((1 << w) < settle + 1) w++;
    return w;
  endfunction

endpackage

// File: rtl/mult_eval_ed.sv
// Exact unsigned product of the current operands and its absolute distance to the candidate.
module mult_eval_ed
  import mult_eval_pkg::*;
#(
  parameter int W = 2
) (
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic [2*W-1:0] cand,
  output logic [2*W-1:0] ed
);

  localparam int PW = pw_of(W);

  logic [PW-1:0] exact;

  always_comb begin
    exact = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    ed    = (cand >= exact) ? (cand - exact) : (exact - cand);
  end

endmodule

// File: rtl/mult_eval_sequencer.sv
// Sweeps all operand pairs through a candidate multiplier and accumulates
// error count, summed error distance and maximum error distance.
module mult_eval_sequencer
  import mult_eval_pkg::*;
#(
  parameter int W      = 2,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             abort_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             result_valid_o,
  output logic [W-1:0]     op_a_o,
  output logic [W-1:0]     op_b_o,
  input  logic [2*W-1:0]   cand_p_i,
  output logic [2*W:0]     err_count_o,
  output logic [4*W-1:0]   err_sum_o,
  output logic [2*W-1:0]   max_ed_o
);

  localparam int PW    = pw_of(W);
  localparam int SUM_W = sum_w_of(W);
  localparam int CNT_W = cnt_w_of(W);
  localparam int CW    = settle_cnt_w(SETTLE);
  localparam logic [CW-1:0] SETTLE_LAST = CW'((SETTLE > 0) ? SETTLE - 1 : 0);

  state_e             state_q, state_d;
  logic [PW-1:0]      idx_q, idx_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [CNT_W-1:0]   ec_q, ec_d;
  logic [SUM_W-1:0]   es_q, es_d;
  logic [PW-1:0]      me_q, me_d;
  logic               rv_q, rv_d;
  logic [PW-1:0]      ed;

  mult_eval_ed #(.W(W)) u_ed (
    .a    (idx_q[W-1:0]),
    .b    (idx_q[PW-1:W]),
    .cand (cand_p_i),
    .ed   (ed)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      ec_q    <= '0;
      es_q    <= '0;
      me_q    <= '0;
      rv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      ec_q    <= ec_d;
      es_q    <= es_d;
      me_q    <= me_d;
      rv_q    <= rv_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    ec_d    = ec_q;
    es_d    = es_q;
    me_d    = me_q;
    rv_d    = rv_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          idx_d   = '0;
          cnt_d   = '0;
          ec_d    = '0;
          es_d    = '0;
          me_d    = '0;
          rv_d    = 1'b0;
          state_d = (SETTLE == 0) ? SAMPLE : DRIVE;
        end
      end
      DRIVE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = '0;
          state_d = SAMPLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      SAMPLE: begin
        ec_d = ec_q + CNT_W'(ed != '0);
        es_d = es_q + SUM_W'(ed);
        me_d = (ed > me_q) ? ed : me_q;
        if (idx_q == '1) begin
          rv_d    = 1'b1;
          state_d = DONE;
        end else begin
          idx_d   = idx_q + PW'(1);
          state_d = (SETTLE == 0) ? SAMPLE : DRIVE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Abort wins over everything in flight, including the final sample.
    if (abort_i && (state_q == DRIVE || state_q == SAMPLE)) begin
      state_d = IDLE;
      idx_d   = '0;
      cnt_d   = '0;
      ec_d    = '0;
      es_d    = '0;
      me_d    = '0;
      rv_d    = 1'b0;
    end
  end

  assign busy_o         = (state_q != IDLE);
  assign done_o         = (state_q == DONE);
  assign result_valid_o = rv_q;
  assign op_a_o         = idx_q[W-1:0];
  assign op_b_o         = idx_q[PW-1:W];
  assign err_count_o    = ec_q;
  assign err_sum_o      = es_q;
  assign max_ed_o       = me_q;

endmodule

// File: tb/tb_mult_eval_sequencer.sv
// Scoreboard bench: three sequencer instances with SETTLE = 0, 1, 2 driving behavioural candidates.
module tb_mult_eval_sequencer;

  localparam int W  = 2;
  localparam int NI = 3;
  localparam int N  = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NI-1:0]      start_s, abort_s, busy_s, done_s, rv_s;
  logic [NI-1:0][1:0] opa, opb;
  logic [NI-1:0][3:0] cand, maxed;
  logic [NI-1:0][4:0] ecnt;
  logic [NI-1:0][7:0] esum;
  int mode [NI];

  int cyc   = 0;
  int n_chk = 0;
  int n_err = 0;

  // expected statistics per candidate kind: 0 exact, 1 approximate low bit, 2 constant zero
  int exp_cnt [3] = '{0, 4, 9};
  int exp_sum [3] = '{0, 4, 36};
  int exp_mx  [3] = '{0, 1, 9};

  typedef struct {
    int inst;
    int cnt;
    int sum;
    int mx;
    int done_at;
  } exp_t;
  exp_t sb[$];

  function automatic logic [3:0] cand_model(input int md, input logic [1:0] a, input logic [1:0] b);
    logic [3:0] p;
    p = {2'b00, a} * {2'b00, b};
    if (md == 1) p[0] = ~a[1] & b[0];
    else if (md == 2) p = 4'd0;
    return p;
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    assign cand[g] = cand_model(mode[g], opa[g], opb[g]);
    mult_eval_sequencer #(.W(W), .SETTLE(g)) u_dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start_i        (start_s[g]),
      .abort_i        (abort_s[g]),
      .busy_o         (busy_s[g]),
      .done_o         (done_s[g]),
      .result_valid_o (rv_s[g]),
      .op_a_o         (opa[g]),
      .op_b_o         (opb[g]),
      .cand_p_i       (cand[g]),
      .err_count_o    (ecnt[g]),
      .err_sum_o      (esum[g]),
      .max_ed_o       (maxed[g])
    );
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic check_cleared(input string tag, input int g);
    check_eq({tag, ".busy"}, 32'(busy_s[g]), 0);
    check_eq({tag, ".done"}, 32'(done_s[g]), 0);
    check_eq({tag, ".valid"}, 32'(rv_s[g]), 0);
    check_eq({tag, ".cnt"}, 32'(ecnt[g]), 0);
    check_eq({tag, ".sum"}, 32'(esum[g]), 0);
    check_eq({tag, ".max"}, 32'(maxed[g]), 0);
    check_eq({tag, ".op_a"}, 32'(opa[g]), 0);
    check_eq({tag, ".op_b"}, 32'(opb[g]), 0);
  endtask

  task automatic run_sweep(input int g, input int md, input bit pester);
    exp_t e;
    exp_t r;
    int acc;
    int k;
    int v;
    bit got;
    mode[g] = md;
    @(negedge clk);
    start_s[g] = 1'b1;
    acc = cyc;
    e.inst = g; e.cnt = exp_cnt[md]; e.sum = exp_sum[md]; e.mx = exp_mx[md];
    e.done_at = acc + N * (g + 1) + 1;
    sb.push_back(e);
    got = 1'b0;
    for (int it = 0; it < 200 && !got; it++) begin
      @(negedge clk);
      k = cyc - acc;
      if (k == 1) begin
        check_eq("sweep.busy_at_start", 32'(busy_s[g]), 1);
        check_eq("sweep.valid_cleared", 32'(rv_s[g]), 0);
      end
      if (g == 2 && !done_s[g] && k >= 1 && k <= 3 * N) begin
        v = (k - 1) / 3;
        check_eq("sweep.op_a", 32'(opa[g]), v % 4);
        check_eq("sweep.op_b", 32'(opb[g]), v / 4);
      end
      if (done_s[g]) begin
        got = 1'b1;
        if (sb.size() == 0) begin
          check_eq("sweep.unexpected_done", 1, 0);
        end else begin
          r = sb.pop_front();
          check_eq("sweep.inst", g, r.inst);
          check_eq("sweep.done_cycle", cyc, r.done_at);
          check_eq("sweep.err_count", 32'(ecnt[g]), r.cnt);
          check_eq("sweep.err_sum", 32'(esum[g]), r.sum);
          check_eq("sweep.max_ed", 32'(maxed[g]), r.mx);
          check_eq("sweep.valid_in_done", 32'(rv_s[g]), 1);
          check_eq("sweep.busy_in_done", 32'(busy_s[g]), 1);
        end
      end
      start_s[g] = pester && (k == 5 || k == 20);
    end
    start_s[g] = 1'b0;
    if (!got) check_eq("sweep.timeout", 0, 1);
    @(negedge clk);
    check_eq("post.done_low", 32'(done_s[g]), 0);
    check_eq("post.busy_low", 32'(busy_s[g]), 0);
    check_eq("post.valid_held", 32'(rv_s[g]), 1);
    check_eq("post.err_sum_held", 32'(esum[g]), exp_sum[md]);
  endtask

  task automatic abort_sweep(input int g, input int md, input int at_k);
    int acc;
    int k;
    int seen;
    mode[g] = md;
    @(negedge clk);
    start_s[g] = 1'b1;
    acc = cyc;
    @(negedge clk);
    start_s[g] = 1'b0;
    seen = 0;
    for (int it = 0; it < N * (g + 1) + 8; it++) begin
      k = cyc - acc;
      if (done_s[g]) seen++;
      if (k == at_k + 1) check_cleared("abort", g);
      abort_s[g] = (k == at_k);
      @(negedge clk);
    end
    abort_s[g] = 1'b0;
    check_eq("abort.no_done", seen, 0);
  endtask

  initial begin
    int acc;
    start_s = '0;
    abort_s = '0;
    for (int g = 0; g < NI; g++) mode[g] = 0;
    repeat (3) @(negedge clk);
    for (int g = 0; g < NI; g++) check_cleared("reset", g);
    rst_n = 1'b1;

    run_sweep(1, 0, 1'b0);
    run_sweep(1, 1, 1'b0);
    run_sweep(0, 2, 1'b0);
    run_sweep(2, 1, 1'b1);

    abort_sweep(1, 2, 15);
    run_sweep(1, 2, 1'b0);
    abort_sweep(0, 2, 16);
    run_sweep(0, 1, 1'b0);

    // asynchronous reset in the middle of vector 10 on the SETTLE=0 instance
    mode[0] = 2;
    @(negedge clk);
    start_s[0] = 1'b1;
    acc = cyc;
    @(negedge clk);
    start_s[0] = 1'b0;
    while (cyc - acc < 11) @(negedge clk);
    check_eq("rst.partial_nonzero", 32'(ecnt[0] != 0), 1);
    #2 rst_n = 1'b0;
    #1;
    for (int g = 0; g < NI; g++) check_cleared("rst_mid", g);
    @(negedge clk);
    rst_n = 1'b1;
    run_sweep(0, 2, 1'b0);

    check_eq("scoreboard.empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
